// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings seen on
// E_mdop and the packed HI/LO pair used for the pending result.
// No ports; imported by mdu_sched.
package mdu_sched_pkg;

  localparam logic [2:0] MDOP_NONE  = 3'd0;
  localparam logic [2:0] MDOP_MULT  = 3'd1;
  localparam logic [2:0] MDOP_MULTU = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_DIVU  = 3'd4;
  localparam logic [2:0] MDOP_MTHI  = 3'd5;
  localparam logic [2:0] MDOP_MTLO  = 3'd6;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // True for the four opcodes that occupy the unit for multiple cycles.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide unit with HI/LO registers and its own busy scheduler.
// Latency: result computed in start cycle 0, busy in cycles 1..N, HI/LO + done visible in cycle N+1.
// Backpressure: md_stall holds any HI/LO-related instruction in D while an op starts or is in flight.
// Ports: clk, reset (sync, active-high); E_mdop/E_rs/E_rt from E; D_md_use from D;
//   E_start, busy, done, hi, lo, md_stall out.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_mdop,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_md_use,
  output logic        E_start,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  hilo_t            pend_q,  pend_d;
  logic [31:0]      hi_q,    hi_d;
  logic [31:0]      lo_q,    lo_d;
  logic             done_q,  done_d;

  // ---------------------------------------------------------------- compute
  logic [63:0] prod_s, prod_u;
  logic        sgn_div, a_neg, b_neg;
  logic [31:0] mag_a, mag_b, dvsr, q_u, r_u, quo, rem;
  hilo_t       result;
  logic [CNT_W-1:0] cnt_load;

  always_comb begin
    prod_s = {{32{E_rs[31]}}, E_rs} * {{32{E_rt[31]}}, E_rt};
    prod_u = {32'd0, E_rs} * {32'd0, E_rt};

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special
    // case: |a| = 0x80000000, quotient keeps that pattern, remainder is 0.
    sgn_div = (E_mdop == MDOP_DIV);
    a_neg   = sgn_div & E_rs[31];
    b_neg   = sgn_div & E_rt[31];
    mag_a   = a_neg ? (32'd0 - E_rs) : E_rs;
    mag_b   = b_neg ? (32'd0 - E_rt) : E_rt;
    // Divisor forced nonzero so the divider never sees /0; that result is discarded.
    dvsr    = (E_rt == 32'd0) ? 32'd1 : mag_b;
    q_u     = mag_a / dvsr;
    r_u     = mag_a % dvsr;
    quo     = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
    rem     = a_neg ? (32'd0 - r_u) : r_u;

    result.hi = hi_q;
    result.lo = lo_q;
    cnt_load  = CNT_W'(DIV_CYCLES);
    case (E_mdop)
      MDOP_MULT: begin
        result   = prod_s;
        cnt_load = CNT_W'(MULT_CYCLES);
      end
      MDOP_MULTU: begin
        result   = prod_u;
        cnt_load = CNT_W'(MULT_CYCLES);
      end
      MDOP_DIV, MDOP_DIVU: begin
        // Divide by zero commits the current HI/LO back, i.e. leaves them unchanged.
        if (E_rt != 32'd0) begin
          result.hi = rem;
          result.lo = quo;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------- scheduler / HI/LO
  assign busy     = (state_q == ST_RUN);
  assign E_start  = is_muldiv(E_mdop) && !busy;
  assign md_stall = D_md_use && (E_start || busy);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (E_start) begin
        pend_d  = result;
        cnt_d   = cnt_load;
        state_d = ST_RUN;
      end else if (E_mdop == MDOP_MTHI) begin
        hi_d = E_rs;
      end else if (E_mdop == MDOP_MTLO) begin
        lo_d = E_rs;
      end
    end else begin
      // Counter holds N in cycle 1 and reaches 1 in cycle N, the commit cycle.
      // Opcodes arriving while busy are ignored here.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        hi_d    = pend_q.hi;
        lo_d    = pend_q.lo;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: expected {hi,lo} pushed at issue, popped by a
// monitor on every done pulse; cycle-level busy/stall/start checks in the stimulus.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  E_mdop;
  logic [31:0] E_rs, E_rt;
  logic        D_md_use;
  logic        E_start, busy, done, md_stall;
  logic [31:0] hi, lo;

  mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_mdop(E_mdop), .E_rs(E_rs), .E_rt(E_rt),
    .D_md_use(D_md_use), .E_start(E_start), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (busy && E_mdop != 3'd0) begin
        errors++;
        $display("FAIL op_while_busy: got op %0d expected 0", E_mdop);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_hilo", {hi, lo}, mon_e);
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int n, input logic use_d);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    E_mdop = op; E_rs = a; E_rt = b; D_md_use = use_d;
    @(negedge clk);
    chk("start_c0", {63'd0, E_start}, 64'd1);
    chk("busy_c0", {63'd0, busy}, 64'd0);
    chk("stall_c0", {63'd0, md_stall}, {63'd0, use_d});
    @(posedge clk); #1;
    E_mdop = 3'd0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      chk("busy_run", {63'd0, busy}, 64'd1);
      chk("done_early", {63'd0, done}, 64'd0);
      chk("hilo_hold", {hi, lo}, {m_hi, m_lo});
      chk("stall_run", {63'd0, md_stall}, {63'd0, use_d});
    end
    @(negedge clk);
    chk("busy_end", {63'd0, busy}, 64'd0);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("stall_end", {63'd0, md_stall}, 64'd0);
    D_md_use = 1'b0;
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic mt_op(input logic [2:0] op, input logic [31:0] v);
    @(posedge clk); #1;
    E_mdop = op; E_rs = v;
    @(negedge clk);
    chk("mt_nostart", {63'd0, E_start}, 64'd0);
    @(posedge clk); #1;
    E_mdop = 3'd0;
    if (op == 3'd5) m_hi = v; else m_lo = v;
    @(negedge clk);
    chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
    chk("mt_busy", {63'd0, busy}, 64'd0);
    chk("mt_done", {63'd0, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; E_mdop = 3'd0; E_rs = '0; E_rt = '0; D_md_use = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    // mult with mfhi waiting in D from cycle 0
    run_op(3'd1, 32'd3, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFA, 5, 1'b1);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 5, 1'b0);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, 1'b0);
    run_op(3'd3, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 10, 1'b0);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, 1'b1);
    run_op(3'd4, 32'd100, 32'd7, 64'h00000002_0000000E, 10, 1'b0);

    mt_op(3'd5, 32'h1234);
    mt_op(3'd6, 32'hABCD);
    mt_op(3'd5, 32'h11);
    mt_op(3'd6, 32'h22);
    run_op(3'd4, 32'd7, 32'd0, 64'h00000011_00000022, 10, 1'b0);

    // Reset asserted in cycle 3 of a div: op discarded, nothing committed.
    @(posedge clk); #1;
    E_mdop = 3'd3; E_rs = 32'd100; E_rt = 32'd3;
    @(posedge clk); #1;
    E_mdop = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;

    run_op(3'd1, 32'd6, 32'd7, 64'h00000000_0000002A, 5, 1'b0);

    repeat (15) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
